// File: rtl/dedisp_if.sv
// Stream and configuration bundle for dedisp_delay_scheduler.
// The master side drives samples and table updates; the slave side is the scheduler.
interface dedisp_if #(
  parameter int N_CHAN    = 64,
  parameter int MAX_DELAY = 32,
  parameter int DIN_WIDTH = 32
);
  localparam int CHAN_W = $clog2(N_CHAN);
  localparam int DLY_W  = $clog2(MAX_DELAY);

  logic [DIN_WIDTH-1:0] din;
  logic                 din_valid;
  logic                 sync_in;
  logic                 cfg_we;
  logic [CHAN_W-1:0]    cfg_chan;
  logic [DLY_W-1:0]     cfg_delay;
  logic                 cfg_commit;
  logic                 cfg_pending;
  logic [DIN_WIDTH-1:0] dout;
  logic                 dout_valid;
  logic                 sync_out;

  modport master (
    output din, din_valid, sync_in, cfg_we, cfg_chan, cfg_delay, cfg_commit,
    input  cfg_pending, dout, dout_valid, sync_out
  );

  modport slave (
    input  din, din_valid, sync_in, cfg_we, cfg_chan, cfg_delay, cfg_commit,
    output cfg_pending, dout, dout_valid, sync_out
  );
endinterface

// File: rtl/dedisp_delay_scheduler.sv
// Per-channel dedispersion delay scheduler: one shared BRAM split into N_CHAN circular regions.
// Optional DEDISP_FRAME_ERR_EN adds a sticky frame_err output flagging misaligned sync_in.
module dedisp_delay_scheduler #(
  parameter int N_CHAN    = 64,
  parameter int MAX_DELAY = 32,
  parameter int DIN_WIDTH = 32
) (
  input  logic     clk,
  input  logic     rst,
`ifdef DEDISP_FRAME_ERR_EN
  dedisp_if.slave  bus,
  output logic     frame_err
`else
  dedisp_if.slave  bus
`endif
);
  localparam int CHAN_W = $clog2(N_CHAN);
  localparam int DLY_W  = $clog2(MAX_DELAY);
  localparam int ADDR_W = CHAN_W + DLY_W;
  localparam int FILL_W = DLY_W + 1;

  typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

  state_t              state, state_nxt;
  logic [CHAN_W-1:0]   chan_cnt;
  logic [DLY_W-1:0]    spec_cnt;
  logic [FILL_W-1:0]   fill_cnt;
  logic [DLY_W-1:0]    active_tbl [N_CHAN];
  logic [DLY_W-1:0]    shadow_tbl [N_CHAN];
  logic                pending;

  logic                accept, misalign, is_ch0, last_ch, copy_now, fill_done, out_en;
  logic [CHAN_W-1:0]   chan_cur;
  logic [DLY_W-1:0]    spec_cur, delay_cur;

  logic                vld_p0, sync_p0, we_p0, byp_p0;
  logic [ADDR_W-1:0]   wr_addr_p0, rd_addr_p0;
  logic [DIN_WIDTH-1:0] din_p0;
  logic                vld_p1, sync_p1, byp_p1;
  logic [DIN_WIDTH-1:0] din_p1, rd_data_p1;
  logic [DIN_WIDTH-1:0] mem [N_CHAN*MAX_DELAY];

  // A misaligned sync forces the sample to be channel 0 of spectrum slot 0.
  assign accept    = bus.din_valid && (state != IDLE || bus.sync_in);
  assign misalign  = accept && bus.sync_in && state != IDLE && chan_cnt != '0;
  assign chan_cur  = misalign ? '0 : chan_cnt;
  assign spec_cur  = misalign ? '0 : spec_cnt;
  assign is_ch0    = chan_cur == '0;
  assign last_ch   = chan_cur == CHAN_W'(N_CHAN - 1);
  assign copy_now  = accept && is_ch0 && pending;
  assign delay_cur = copy_now ? shadow_tbl[chan_cur] : active_tbl[chan_cur];
  assign fill_done = fill_cnt == FILL_W'(MAX_DELAY);

  always_comb begin
    state_nxt = state;
    out_en    = 1'b0;
    case (state)
      IDLE: if (accept) state_nxt = FILL;
      FILL: begin
        if (accept && !misalign && is_ch0 && fill_done) begin
          state_nxt = RUN;
          out_en    = 1'b1;
        end
      end
      RUN: begin
        if (misalign) state_nxt = FILL;
        else          out_en    = accept;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      chan_cnt <= '0;
      spec_cnt <= '0;
      fill_cnt <= '0;
    end else if (accept) begin
      chan_cnt <= last_ch ? '0 : chan_cur + 1'b1;
      spec_cnt <= last_ch ? spec_cur + 1'b1 : spec_cur;
      if (misalign)                    fill_cnt <= '0;
      else if (last_ch && !fill_done)  fill_cnt <= fill_cnt + 1'b1;
    end
  end

  // The copy reads shadow_tbl before any same-cycle cfg_we lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_CHAN; i++) begin
        active_tbl[i] <= '0;
        shadow_tbl[i] <= '0;
      end
      pending <= 1'b0;
    end else begin
      if (bus.cfg_we) shadow_tbl[bus.cfg_chan] <= bus.cfg_delay;
      if (copy_now)   active_tbl <= shadow_tbl;
      if (copy_now)            pending <= 1'b0;
      else if (bus.cfg_commit) pending <= 1'b1;
    end
  end

  // Stage p0: address register
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0  <= 1'b0;
      sync_p0 <= 1'b0;
      we_p0   <= 1'b0;
    end else begin
      vld_p0  <= out_en;
      sync_p0 <= out_en && is_ch0;
      we_p0   <= accept;
    end
  end

  always_ff @(posedge clk) begin
    wr_addr_p0 <= {chan_cur, spec_cur};
    rd_addr_p0 <= {chan_cur, DLY_W'(spec_cur - delay_cur)};
    byp_p0     <= delay_cur == '0;
    din_p0     <= bus.din;
  end

  // Stage p1: BRAM read; zero delay bypasses the array to avoid read-during-write
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      vld_p1  <= vld_p0;
      sync_p1 <= sync_p0;
    end
  end

  always_ff @(posedge clk) begin
    if (we_p0) mem[wr_addr_p0] <= din_p0;
    rd_data_p1 <= mem[rd_addr_p0];
    din_p1     <= din_p0;
    byp_p1     <= byp_p0;
  end

  assign bus.dout_valid  = vld_p1;
  assign bus.sync_out    = sync_p1;
  assign bus.dout        = vld_p1 ? (byp_p1 ? din_p1 : rd_data_p1) : '0;
  assign bus.cfg_pending = pending;

`ifdef DEDISP_FRAME_ERR_EN
  always_ff @(posedge clk) begin
    if (rst)           frame_err <= 1'b0;
    else if (misalign) frame_err <= 1'b1;
  end
`endif
endmodule

// File: tb/tb_dedisp_delay_scheduler.sv
// Self-checking bench for dedisp_delay_scheduler (N_CHAN=4, MAX_DELAY=8): row table plus
// hand sequences for commit timing, realignment and mid-run reset, with a timed scoreboard.
module tb_dedisp_delay_scheduler;
  localparam int N_CHAN    = 4;
  localparam int MAX_DELAY = 8;
  localparam int DIN_WIDTH = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dedisp_if #(.N_CHAN(N_CHAN), .MAX_DELAY(MAX_DELAY), .DIN_WIDTH(DIN_WIDTH)) bus ();
`ifdef DEDISP_FRAME_ERR_EN
  logic frame_err;
`endif

  dedisp_delay_scheduler #(.N_CHAN(N_CHAN), .MAX_DELAY(MAX_DELAY), .DIN_WIDTH(DIN_WIDTH)) dut (
    .clk (clk),
    .rst (rst),
`ifdef DEDISP_FRAME_ERR_EN
    .bus (bus),
    .frame_err (frame_err)
`else
    .bus (bus)
`endif
  );

  typedef struct {
    logic [31:0] due;
    logic [31:0] data;
    logic        sync;
  } exp_t;

  typedef struct {
    bit commit;
    int d0, d1, d2, d3;
    bit gap;
    int nspec;
    int nfill;
  } row_t;

  exp_t        q[$];
  exp_t        mon_e;
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] cyc      = 0;
  bit          mon_en   = 1'b0;
  int          cur_d [4] = '{0, 0, 0, 0};
  int          s_abs    = 0;
  row_t        rows [3];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (q.size() > 0 && q[0].due == cyc) begin
        mon_e = q.pop_front();
        chk("dout_valid", 32'(bus.dout_valid), 32'd1);
        chk("dout", bus.dout, mon_e.data);
        chk("sync_out", 32'(bus.sync_out), 32'(mon_e.sync));
      end else begin
        chk("dout_valid_idle", 32'(bus.dout_valid), 32'd0);
      end
    end
  end

  function automatic int row_d(input row_t r, input int c);
    case (c)
      0: return r.d0;
      1: return r.d1;
      2: return r.d2;
      default: return r.d3;
    endcase
  endfunction

  task automatic drive_sample(input int c, input int s, input bit sync, input bit ev,
                              input bit gap, input logic [31:0] exp_data);
    if (gap) begin
      bus.din_valid = 1'b0;
      bus.sync_in   = 1'b0;
      @(posedge clk); #1;
    end
    bus.din       = 32'(s * 16 + c);
    bus.din_valid = 1'b1;
    bus.sync_in   = sync;
    @(posedge clk); #1;
    if (ev) q.push_back('{cyc + 1, exp_data, c == 0});
    bus.din_valid  = 1'b0;
    bus.sync_in    = 1'b0;
    bus.cfg_we     = 1'b0;
    bus.cfg_commit = 1'b0;
  endtask

  task automatic drive_spectrum(input int s, input bit ev, input bit gap);
    for (int c = 0; c < N_CHAN; c++)
      drive_sample(c, s, c == 0, ev, gap, 32'((s - cur_d[c]) * 16 + c));
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rows[0] = '{commit: 1'b0, d0: 0, d1: 0, d2: 0, d3: 0, gap: 1'b0, nspec: 12, nfill: 8};
    rows[1] = '{commit: 1'b1, d0: 0, d1: 1, d2: 2, d3: 7, gap: 1'b0, nspec: 10, nfill: 0};
    rows[2] = '{commit: 1'b1, d0: 0, d1: 1, d2: 2, d3: 7, gap: 1'b1, nspec: 6,  nfill: 0};

    bus.din = '0; bus.din_valid = 1'b0; bus.sync_in = 1'b0;
    bus.cfg_we = 1'b0; bus.cfg_chan = '0; bus.cfg_delay = '0; bus.cfg_commit = 1'b0;
    rst = 1'b1;
    idle_cycles(3);
    rst = 1'b0;
    chk("rst_dout_valid", 32'(bus.dout_valid), 32'd0);
    chk("rst_sync_out", 32'(bus.sync_out), 32'd0);
    chk("rst_cfg_pending", 32'(bus.cfg_pending), 32'd0);
    chk("rst_dout", bus.dout, 32'd0);
    mon_en = 1'b1;

    // Table rows: fill, delay set {0,1,2,7}, same delays with din_valid gaps
    for (int r = 0; r < 3; r++) begin
      if (rows[r].commit) begin
        for (int c = 0; c < N_CHAN; c++) begin
          bus.cfg_we    = 1'b1;
          bus.cfg_chan  = 2'(c);
          bus.cfg_delay = 3'(row_d(rows[r], c));
          @(posedge clk); #1;
        end
        bus.cfg_we     = 1'b0;
        bus.cfg_commit = 1'b1;
        @(posedge clk); #1;
        bus.cfg_commit = 1'b0;
        chk("cfg_pending_set", 32'(bus.cfg_pending), 32'd1);
        for (int c = 0; c < N_CHAN; c++) cur_d[c] = row_d(rows[r], c);
      end
      for (int k = 0; k < rows[r].nspec; k++) begin
        drive_spectrum(s_abs, k >= rows[r].nfill, rows[r].gap);
        if (k == 0) chk("cfg_pending_after_ch0", 32'(bus.cfg_pending), 32'd0);
        s_abs++;
      end
    end

    // Delay change in RUN: write ch2=5 at ch0, commit at ch1
    bus.cfg_we = 1'b1; bus.cfg_chan = 2'd2; bus.cfg_delay = 3'd5;
    drive_sample(0, s_abs, 1'b1, 1'b1, 1'b0, 32'(s_abs * 16));
    bus.cfg_commit = 1'b1;
    drive_sample(1, s_abs, 1'b0, 1'b1, 1'b0, 32'((s_abs - 1) * 16 + 1));
    chk("pending_mid_spec", 32'(bus.cfg_pending), 32'd1);
    drive_sample(2, s_abs, 1'b0, 1'b1, 1'b0, 32'((s_abs - 2) * 16 + 2));
    drive_sample(3, s_abs, 1'b0, 1'b1, 1'b0, 32'((s_abs - 7) * 16 + 3));
    chk("pending_end_spec", 32'(bus.cfg_pending), 32'd1);
    s_abs++;
    cur_d[2] = 5;
    drive_spectrum(s_abs, 1'b1, 1'b0);
    chk("pending_cleared", 32'(bus.cfg_pending), 32'd0);
    s_abs++;
    drive_spectrum(s_abs, 1'b1, 1'b0);
    s_abs++;

    // Misaligned sync at channel position 2: in-flight ch0/ch1 drain, then refill
    drive_sample(0, s_abs, 1'b1, 1'b1, 1'b0, 32'((s_abs - cur_d[0]) * 16));
    drive_sample(1, s_abs, 1'b0, 1'b1, 1'b0, 32'((s_abs - cur_d[1]) * 16 + 1));
`ifdef DEDISP_FRAME_ERR_EN
    chk("frame_err_before", 32'(frame_err), 32'd0);
`endif
    s_abs++;
    drive_spectrum(s_abs, 1'b0, 1'b0);
`ifdef DEDISP_FRAME_ERR_EN
    chk("frame_err_after", 32'(frame_err), 32'd1);
`endif
    s_abs++;
    for (int k = 0; k < 7; k++) begin
      drive_spectrum(s_abs, 1'b0, 1'b0);
      s_abs++;
    end
    for (int k = 0; k < 2; k++) begin
      drive_spectrum(s_abs, 1'b1, 1'b0);
      s_abs++;
    end
`ifdef DEDISP_FRAME_ERR_EN
    chk("frame_err_sticky", 32'(frame_err), 32'd1);
`endif

    // Reset mid-RUN with a commit pending and a sample in flight
    drive_sample(0, s_abs, 1'b1, 1'b1, 1'b0, 32'((s_abs - cur_d[0]) * 16));
    bus.cfg_commit = 1'b1;
    @(posedge clk); #1;
    bus.cfg_commit = 1'b0;
    chk("pending_before_rst", 32'(bus.cfg_pending), 32'd1);
    drive_sample(1, s_abs, 1'b0, 1'b1, 1'b0, 32'((s_abs - cur_d[1]) * 16 + 1));
    rst = 1'b1;
    @(posedge clk); #1;
    q.delete();
    rst = 1'b0;
    chk("mid_rst_dout_valid", 32'(bus.dout_valid), 32'd0);
    chk("mid_rst_cfg_pending", 32'(bus.cfg_pending), 32'd0);
    chk("mid_rst_sync_out", 32'(bus.sync_out), 32'd0);
    chk("mid_rst_dout", bus.dout, 32'd0);
`ifdef DEDISP_FRAME_ERR_EN
    chk("mid_rst_frame_err", 32'(frame_err), 32'd0);
`endif
    s_abs++;
    for (int c = 0; c < N_CHAN; c++) drive_sample(c, s_abs, 1'b0, 1'b0, 1'b0, 32'd0);
    s_abs++;
    for (int c = 0; c < N_CHAN; c++) cur_d[c] = 0;
    for (int k = 0; k < 10; k++) begin
      drive_spectrum(s_abs, k >= 8, 1'b0);
      s_abs++;
    end

    idle_cycles(4);
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
